// File: rtl/short_preamble_inserter_pkg.sv
// sts_pkg: 802.11a short training sequence table, sample type and inserter states
package sts_pkg;

    localparam int STS_LEN = 16;

    typedef struct packed {
        logic signed [15:0] i;
        logic signed [15:0] q;
    } cplx16_t;

    localparam cplx16_t STS_TABLE [STS_LEN] = '{
        '{16'sd1507,  16'sd1507},
        '{-16'sd4325, 16'sd66},
        '{-16'sd426,  -16'sd2589},
        '{16'sd4686,  -16'sd426},
        '{16'sd3015,  16'sd0},
        '{16'sd4686,  -16'sd426},
        '{-16'sd426,  -16'sd2589},
        '{-16'sd4325, 16'sd66},
        '{16'sd1507,  16'sd1507},
        '{16'sd66,    -16'sd4325},
        '{-16'sd2589, -16'sd426},
        '{-16'sd426,  16'sd4686},
        '{16'sd0,     16'sd3015},
        '{-16'sd426,  16'sd4686},
        '{-16'sd2589, -16'sd426},
        '{16'sd66,    -16'sd4325}
    };

    typedef enum logic [1:0] {S_IDLE, S_ZEROS, S_STS, S_PAYLOAD} state_t;

endpackage

// File: rtl/short_preamble_inserter_sts_rom.sv
// sts_rom: registered STS lookup with sign-preserving gain shift on I and Q
module sts_rom
    import sts_pkg::*;
#(
    parameter int GAIN_SHIFT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  addr,
    output logic [31:0] data
);

    logic [31:0] data_d, data_q;

    always_comb data_d = {$signed(STS_TABLE[addr].i) >>> GAIN_SHIFT,
                          $signed(STS_TABLE[addr].q) >>> GAIN_SHIFT};

    always_ff @(posedge clk) data_q <= reset ? '0 : data_d;

    assign data = data_q;

endmodule

// File: rtl/short_preamble_inserter.sv
// short_preamble_inserter: prepends optional zeros and NUM_PERIODS STS repeats to each AXI-Stream packet
module short_preamble_inserter
    import sts_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUM_PERIODS = 10,
    parameter int PRE_ZEROS   = 0,
    parameter int GAIN_SHIFT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             o_sop,
    output logic             o_busy
);

    state_t      state_d, state_q;
    logic [7:0]  zcnt_d, zcnt_q;
    logic [3:0]  idx_d, idx_q, per_d, per_q;
    logic        sop_d, sop_q, acc, payload;
    logic [31:0] rom_data;

    // ROM is addressed with the next index so its registered output tracks idx_q
    sts_rom #(.GAIN_SHIFT(GAIN_SHIFT)) u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  (idx_d),
        .data  (rom_data)
    );

    assign payload  = state_q == S_PAYLOAD;
    assign o_tvalid = payload ? i_tvalid : (state_q == S_ZEROS || state_q == S_STS);
    assign o_tdata  = payload ? i_tdata : (state_q == S_STS ? rom_data : '0);
    assign o_tlast  = payload & i_tlast;
    assign i_tready = payload & o_tready;
    assign o_sop    = sop_q;
    assign o_busy   = state_q != S_IDLE;
    assign acc      = o_tvalid & o_tready;

    always_comb begin
        state_d = state_q;
        zcnt_d  = zcnt_q;
        idx_d   = idx_q;
        per_d   = per_q;
        sop_d   = sop_q;
        case (state_q)
            S_IDLE: if (i_tvalid) begin
                state_d = PRE_ZEROS > 0 ? S_ZEROS : S_STS;
                sop_d   = 1'b1;
            end
            S_ZEROS: if (acc) begin
                sop_d  = 1'b0;
                zcnt_d = zcnt_q + 8'd1;
                if (zcnt_q == 8'(PRE_ZEROS - 1)) begin
                    state_d = S_STS;
                    zcnt_d  = '0;
                end
            end
            S_STS: if (acc) begin
                sop_d = 1'b0;
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'(STS_LEN - 1)) begin
                    per_d = per_q + 4'd1;
                    if (per_q == 4'(NUM_PERIODS - 1)) begin
                        state_d = S_PAYLOAD;
                        per_d   = '0;
                    end
                end
            end
            S_PAYLOAD: if (i_tvalid & o_tready & i_tlast) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            zcnt_q  <= '0;
            idx_q   <= '0;
            per_q   <= '0;
            sop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            zcnt_q  <= zcnt_d;
            idx_q   <= idx_d;
            per_q   <= per_d;
            sop_q   <= sop_d;
        end
    end

endmodule
